// File: rtl/clk_divider_prog.sv
// Programmable clock divider with shadowed half-period reload.
// Optional TICK_OUT_EN macro adds a one-cycle tick on each rising wrap.
module clk_divider_prog #(
    parameter int          CNT_W    = 16,
    parameter int unsigned HALF_RST = 500
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             half_ld,
    input  logic [CNT_W-1:0] half_val,
    output logic             half_pend,
    output logic             half_err,
    output logic             clk_out,
`ifdef TICK_OUT_EN
    output logic             tick,
`endif
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(HALF_RST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] half_act;
    logic [CNT_W-1:0] half_shd;
    logic             wrap;
    logic             ld_ok;
    logic             ld_bad;
    logic             apply;

    // Wrap uses >= so a stray cnt above half_act still recovers.
    always_comb begin
        wrap   = en && (cnt >= half_act);
        ld_ok  = half_ld && (half_val != '0);
        ld_bad = half_ld && (half_val == '0);
        apply  = half_pend && (sync_clr || wrap);
    end

    // Phase counter and divided output; sync_clr wins over counting.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= ONE;
            clk_out <= 1'b0;
        end else if (sync_clr) begin
            cnt     <= ONE;
            clk_out <= 1'b0;
        end else if (wrap) begin
            cnt     <= ONE;
            clk_out <= ~clk_out;
        end else if (en) begin
            cnt     <= cnt + ONE;
        end
    end

    // Active half-period only changes on a period boundary or clear.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            half_act <= HALF_INIT;
        end else if (apply) begin
            half_act <= half_shd;
        end
    end

    // Shadow register and pending flag; a new load beats the apply.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            half_shd  <= HALF_INIT;
            half_pend <= 1'b0;
        end else if (ld_ok) begin
            half_shd  <= half_val;
            half_pend <= 1'b1;
        end else if (apply) begin
            half_pend <= 1'b0;
        end
    end

    // Zero half-period is rejected with a one-cycle error pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            half_err <= 1'b0;
        end else begin
            half_err <= ld_bad;
        end
    end

`ifdef TICK_OUT_EN
    logic tick_q;

    // Registered so the pulse lines up with clk_out going high.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= !sync_clr && wrap && !clk_out;
        end
    end

    // Masked so tick never shows while frozen or clearing.
    always_comb begin
        tick = tick_q && en && !sync_clr;
    end
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog.
// Vector table plus hand sequences for long and async cases.
module tb_clk_divider_prog;

    logic        clk_in;
    logic        rst_n;
    logic        en;
    logic        sync_clr;
    logic        half_ld;
    logic [15:0] half_val;
    logic        half_pend;
    logic        half_err;
    logic        clk_out;
    logic [15:0] cnt;
`ifdef TICK_OUT_EN
    logic        tick;
`endif

    int tests = 0;
    int fails = 0;

    clk_divider_prog #(
        .CNT_W    (16),
        .HALF_RST (500)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .sync_clr  (sync_clr),
        .half_ld   (half_ld),
        .half_val  (half_val),
        .half_pend (half_pend),
        .half_err  (half_err),
        .clk_out   (clk_out),
`ifdef TICK_OUT_EN
        .tick      (tick),
`endif
        .cnt       (cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        clr;
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [15:0] e_cnt;
        logic        e_clk;
        logic        e_pend;
        logic        e_err;
        logic        e_tick;
    } vec_t;

    vec_t tbl[35];

    function automatic vec_t mk(logic c, logic e, logic l, int v,
                                int ec, logic ek, logic ep,
                                logic ee, logic et);
        vec_t r;
        r.clr    = c;
        r.en     = e;
        r.ld     = l;
        r.val    = 16'(v);
        r.e_cnt  = 16'(ec);
        r.e_clk  = ek;
        r.e_pend = ep;
        r.e_err  = ee;
        r.e_tick = et;
        return r;
    endfunction

    task automatic chk(input string nm, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_in();
        en       = 1'b0;
        sync_clr = 1'b0;
        half_ld  = 1'b0;
        half_val = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        #12;
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;

        // clr en ld val | cnt clk pend err tick
        tbl[0]  = mk(0, 0, 1, 3, 1, 0, 1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 2, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 3, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 2, 1, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 3, 1, 0, 1, 0);
        tbl[7]  = mk(0, 1, 1, 5, 1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 2, 0, 1, 0, 0);
        tbl[9]  = mk(0, 1, 1, 6, 3, 0, 1, 0, 0);
        tbl[10] = mk(0, 1, 1, 4, 1, 1, 1, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, 2, 1, 1, 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 3, 1, 1, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 4, 1, 1, 0, 0);
        tbl[14] = mk(0, 1, 0, 0, 5, 1, 1, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 6, 1, 1, 0, 0);
        tbl[16] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 2, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 0, 3, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 0, 0, 4, 0, 0, 0, 0);
        tbl[20] = mk(0, 1, 0, 0, 1, 1, 0, 0, 1);
        tbl[21] = mk(1, 1, 1, 3, 1, 0, 1, 0, 0);
        tbl[22] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[23] = mk(0, 0, 1, 6, 1, 0, 1, 0, 0);
        tbl[24] = mk(0, 1, 0, 0, 2, 0, 1, 0, 0);
        tbl[25] = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);
        tbl[26] = mk(0, 1, 0, 0, 2, 0, 0, 0, 0);
        tbl[27] = mk(0, 1, 0, 0, 3, 0, 0, 0, 0);
        tbl[28] = mk(0, 1, 0, 0, 4, 0, 0, 0, 0);
        tbl[29] = mk(0, 1, 0, 0, 5, 0, 0, 0, 0);
        tbl[30] = mk(0, 1, 0, 0, 6, 0, 0, 0, 0);
        tbl[31] = mk(0, 1, 0, 0, 1, 1, 0, 0, 1);
        tbl[32] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[33] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[34] = mk(0, 1, 0, 0, 2, 1, 0, 0, 0);

        // Reset values
        do_reset();
        chk("rst_cnt", int'(cnt), 1);
        chk("rst_clk", int'(clk_out), 0);
        chk("rst_pend", int'(half_pend), 0);
        chk("rst_err", int'(half_err), 0);
`ifdef TICK_OUT_EN
        chk("rst_tick", int'(tick), 0);
`endif

        // Vector table
        for (int i = 0; i < 35; i++) begin
            sync_clr = tbl[i].clr;
            en       = tbl[i].en;
            half_ld  = tbl[i].ld;
            half_val = tbl[i].val;
            step();
            chk($sformatf("v%0d_cnt", i), int'(cnt), int'(tbl[i].e_cnt));
            chk($sformatf("v%0d_clk", i), int'(clk_out), int'(tbl[i].e_clk));
            chk($sformatf("v%0d_pend", i), int'(half_pend), int'(tbl[i].e_pend));
            chk($sformatf("v%0d_err", i), int'(half_err), int'(tbl[i].e_err));
`ifdef TICK_OUT_EN
            chk($sformatf("v%0d_tick", i), int'(tick), int'(tbl[i].e_tick));
`endif
        end

        // Async reset with a pending load; load must be discarded
        idle_in();
        en       = 1'b1;
        half_ld  = 1'b1;
        half_val = 16'd9;
        step();
        half_ld  = 1'b0;
        chk("ar_pre_pend", int'(half_pend), 1);
        chk("ar_pre_cnt", int'(cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", int'(cnt), 1);
        chk("ar_clk", int'(clk_out), 0);
        chk("ar_pend", int'(half_pend), 0);
        chk("ar_err", int'(half_err), 0);
`ifdef TICK_OUT_EN
        chk("ar_tick", int'(tick), 0);
`endif
        @(negedge clk_in);
        rst_n = 1'b1;
        step();
        chk("ar_resume", int'(cnt), 2);
        for (int k = 0; k < 10; k++) step();
        chk("ar_no9", int'(cnt), 12);
        chk("ar_no9_clk", int'(clk_out), 0);

        // Default 500 half-period over 2000 cycles
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            step();
            chk("run_cnt", int'(cnt), (k % 500) + 1);
            chk("run_clk", int'(clk_out), (k / 500) % 2);
        end

        // Reload 4 at cnt=200, applied at the 500 wrap
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 199; k++) step();
        chk("ld_at200", int'(cnt), 200);
        half_ld  = 1'b1;
        half_val = 16'd4;
        step();
        half_ld  = 1'b0;
        chk("ld_pend", int'(half_pend), 1);
        chk("ld_cnt", int'(cnt), 201);
        for (int k = 201; k < 500; k++) step();
        chk("ld_c500", int'(cnt), 500);
        chk("ld_p500", int'(half_pend), 1);
        chk("ld_k500", int'(clk_out), 0);
        step();
        chk("ld_wcnt", int'(cnt), 1);
        chk("ld_wclk", int'(clk_out), 1);
        chk("ld_wpend", int'(half_pend), 0);
        for (int j = 1; j <= 16; j++) begin
            step();
            chk("p8_cnt", int'(cnt), (j % 4) + 1);
            chk("p8_clk", int'(clk_out), 1 ^ ((j / 4) % 2));
        end

        // Freeze at cnt=7 for 10 cycles
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("fz_cnt7", int'(cnt), 7);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("fz_hold", int'(cnt), 7);
            chk("fz_clk", int'(clk_out), 0);
        end
        en = 1'b1;
        step();
        chk("fz_resume", int'(cnt), 8);

`ifdef TICK_OUT_EN
        // half_act=1: toggle every cycle, tick on every rise
        do_reset();
        half_ld  = 1'b1;
        half_val = 16'd1;
        step();
        half_ld  = 1'b0;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        en       = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("h1_cnt", int'(cnt), 1);
            chk("h1_clk", int'(clk_out), j % 2);
            chk("h1_tick", int'(tick), j % 2);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter CNT_W, default 16: width of the counter and of the half-period value.
REQ-002 Parameter HALF_RST, default 500: half-period in input cycles after reset; gives 1 Hz from 1 kHz.
REQ-003 clk_in  input  1: input clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 en  input  1: count enable; low freezes the counter and clk_out.
REQ-006 sync_clr  input  1: synchronous restart of the divider phase.
REQ-007 half_ld  input  1: single-cycle request to load a new half-period.
REQ-008 half_val  input  CNT_W: half-period value, sampled when half_ld=1.
REQ-009 half_pend  output  1: high while a loaded value waits to be applied.
REQ-010 half_err  output  1: one-cycle pulse when a load is rejected.
REQ-011 clk_out  output  1: divided square wave.
REQ-012 cnt  output  CNT_W: current counter value, 1..half_act.
REQ-013 tick  output  1: one-cycle pulse; present only with TICK_OUT_EN.

Function
REQ-014 The block holds two registers: active half-period half_act and shadow half_shd.
REQ-015 With en=1, cnt increments by 1 each cycle.
REQ-016 When cnt==half_act, the next cycle sets cnt=1 and toggles clk_out (the wrap event).
REQ-017 The output period is therefore 2*half_act input cycles at 50% duty; half_act=1 toggles clk_out every cycle.
REQ-018 half_ld=1 with half_val!=0 writes half_shd and sets half_pend=1 on the next edge.
REQ-019 half_ld=1 with half_val==0 leaves half_shd and half_pend unchanged and pulses half_err for one cycle.
REQ-020 When half_pend=1, the next wrap event copies half_shd into half_act and clears half_pend, so the current half-period always completes glitch-free.
REQ-021 A second load while half_pend=1 overwrites half_shd; only the last value is applied.
REQ-022 If a load coincides with a wrap, the wrap applies the old half_shd and the new value stays pending.
REQ-023 sync_clr=1 (priority over en and the wrap) sets cnt=1 and clk_out=0.
REQ-024 sync_clr=1 also applies a pending half_shd immediately and clears half_pend.
REQ-025 sync_clr=1 together with half_ld=1 behaves as clear first, then load: the new value is pending.
REQ-026 en=0 holds cnt, clk_out and half_act; loads are still accepted; tick=0.
REQ-027 Counter arithmetic is unsigned CNT_W bits; cnt never exceeds half_act and never equals 0 after reset.

Reset
REQ-028 rst_n=0 asynchronously forces cnt=1, clk_out=0, half_act=HALF_RST, half_shd=HALF_RST, half_pend=0, half_err=0 and tick=0.
REQ-029 A reset asserted mid-period or with a pending load discards the pending load; counting resumes from cnt=1 on the first edge after release.

Configuration
REQ-030 Macro TICK_OUT_EN defined: tick pulses high for one cycle in the cycle clk_out becomes 1 (rising wrap); tick is never high during sync_clr or en=0.
REQ-031 Macro TICK_OUT_EN undefined: the tick port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset with defaults, en=1 for 2000 cycles -> clk_out toggles at cycles 500, 1000, 1500 and 2000; cnt sequence is 1..500 repeating.
REQ-033 half_ld with half_val=4 at cnt=200 -> half_pend=1; the current half completes at 500, then the period becomes 8 cycles; half_pend clears at the wrap.
REQ-034 half_ld with half_val=0 -> half_err pulses once; half_pend=0; the period is unchanged.
REQ-035 half_act=3, sync_clr at cnt=2 while a value of 6 is pending -> cnt=1, clk_out=0, half_act=6, half_pend=0.
REQ-036 en=0 for 10 cycles at cnt=7 -> cnt and clk_out hold; after en=1 counting resumes at 8.
REQ-037 TICK_OUT_EN defined, half_act=1 -> tick is high every second cycle, coincident with clk_out rising; rst_n pulsed mid-run -> all outputs return to reset values at once.
